// File: rtl/periph_xbar.sv
// periph_xbar -- single-master peripheral crossbar with wait-state handling.
//
// Decodes cpu_addr_i[31:24] as a one-hot slave select (slave k at 1 << k),
// broadcasts the low address/data/byte-enables to every slave, and stalls
// the CPU while the selected slave holds slv_ready_i low.
//
// Optional feature (macro PERIPH_XBAR_TIMEOUT_EN): wait-state timeout after
// TIMEOUT_CYCLES, plus a sticky bus-error flag with captured address for
// timeouts and unmapped accesses. Without the macro WAIT never times out and
// the error outputs are tied to 0.
//
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   cpu_en_i, cpu_we_i        CPU request, byte write enables (0 = read)
//   cpu_addr_i, cpu_data_i    CPU address and write data
//   cpu_data_o                read data, valid the cycle after completion
//   cpu_stall_o               CPU holds its request while high
//   slv_en_o                  one-hot slave select
//   slv_we_o/addr_o/data_o    broadcast request fields
//   slv_data_i, slv_ready_i   per-slave read data (32 bits each) and ready
//   err_clr_i                 clears bus_err_irq_o / err_addr_o
//   bus_err_irq_o, err_addr_o sticky error flag and first error address
module periph_xbar #(
  parameter int N_SLAVES       = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cpu_en_i,
  input  logic [3:0]            cpu_we_i,
  input  logic [31:0]           cpu_addr_i,
  input  logic [31:0]           cpu_data_i,
  output logic [31:0]           cpu_data_o,
  output logic                  cpu_stall_o,
  output logic [N_SLAVES-1:0]   slv_en_o,
  output logic [3:0]            slv_we_o,
  output logic [23:0]           slv_addr_o,
  output logic [31:0]           slv_data_o,
  input  logic [N_SLAVES*32-1:0] slv_data_i,
  input  logic [N_SLAVES-1:0]   slv_ready_i,
  input  logic                  err_clr_i,
  output logic                  bus_err_irq_o,
  output logic [31:0]           err_addr_o
);

  localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  typedef enum logic {ST_IDLE, ST_WAIT} state_e;

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               rdsel_vld_q;
  logic [IDX_W-1:0]   rdsel_q;

  logic [N_SLAVES-1:0] sel_oh;
  logic [IDX_W-1:0]    sel_idx;
  logic                sel_hit;
  logic                sel_ready;
  logic                is_read;
  logic                rd_load;
  logic                err_set;

  assign slv_we_o   = cpu_we_i;
  assign slv_addr_o = cpu_addr_i[23:0];
  assign slv_data_o = cpu_data_i;
  assign is_read    = (cpu_we_i == 4'h0);

  // Address decode: only exact one-hot patterns within range are mapped.
  always_comb begin
    sel_oh  = '0;
    sel_idx = '0;
    for (int unsigned k = 0; k < N_SLAVES; k++) begin
      if (cpu_addr_i[31:24] == 8'(1 << k)) begin
        sel_oh[k] = 1'b1;
        sel_idx   = IDX_W'(k);
      end
    end
  end

  assign sel_hit   = |sel_oh;
  assign sel_ready = |(slv_ready_i & sel_oh);

  // Next state and combinational outputs. Everything is gated by rst_ni so
  // that asserting reset forces the outputs low without waiting for a clock.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cpu_stall_o = 1'b0;
    slv_en_o    = '0;
    rd_load     = 1'b0;
    err_set     = 1'b0;
    if (rst_ni) begin
      unique case (state_q)
        ST_IDLE: begin
          if (cpu_en_i) begin
            if (sel_hit) begin
              slv_en_o = sel_oh;
              if (sel_ready) begin
                rd_load = is_read;
              end else begin
                cpu_stall_o = 1'b1;
                state_d     = ST_WAIT;
                cnt_d       = 8'd1;
              end
            end else begin
              err_set = 1'b1;
            end
          end
        end
        ST_WAIT: begin
          // A dropped (or changed-to-unmapped) request abandons the access
          // silently; the CPU has given up on it.
          if (!cpu_en_i || !sel_hit) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
`ifdef PERIPH_XBAR_TIMEOUT_EN
          else if (cnt_q == 8'(TIMEOUT_CYCLES)) begin
            err_set = 1'b1;
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
`endif
          else begin
            slv_en_o = sel_oh;
            if (sel_ready) begin
              rd_load = is_read;
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else begin
              cpu_stall_o = 1'b1;
              cnt_d       = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rdsel_vld_q <= 1'b0;
      rdsel_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rdsel_vld_q <= rd_load;
      rdsel_q     <= rd_load ? sel_idx : '0;
    end
  end

  // Read data is steered from the slave captured at completion, so it is
  // valid for exactly the one cycle after a read completes.
  always_comb begin
    cpu_data_o = '0;
    for (int unsigned k = 0; k < N_SLAVES; k++) begin
      if (rdsel_vld_q && (rdsel_q == IDX_W'(k))) begin
        cpu_data_o = slv_data_i[32*k +: 32];
      end
    end
  end

`ifdef PERIPH_XBAR_TIMEOUT_EN
  logic        irq_q;
  logic [31:0] err_addr_q;

  // A new error in the same cycle as a clear wins: it re-arms the flag and
  // records its own address rather than being treated as a repeat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_q      <= 1'b0;
      err_addr_q <= '0;
    end else if (err_set) begin
      irq_q <= 1'b1;
      if (!irq_q || err_clr_i) begin
        err_addr_q <= cpu_addr_i;
      end
    end else if (err_clr_i) begin
      irq_q      <= 1'b0;
      err_addr_q <= '0;
    end
  end

  assign bus_err_irq_o = irq_q;
  assign err_addr_o    = err_addr_q;
`else
  logic unused_err;
  assign unused_err    = &{1'b0, err_clr_i, err_set, 8'(TIMEOUT_CYCLES)};
  assign bus_err_irq_o = 1'b0;
  assign err_addr_o    = '0;
`endif

endmodule
